// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS HI/LO unit: MULT/MULTU/DIV/DIVU with MTHI/MTLO, stalls the pipeline while busy.
// Optional MDU_FAST_MUL_EN: single-cycle multiply; the divide path stays iterative.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_valid,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             exception,
  output logic             mult_div_run,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   ma_q, mb_q;
  logic [2*WIDTH-1:0] p_q;
  logic               neg_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_mul, is_div, is_signed, issue, busy;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_upper, div_rs, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_res;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign is_mul    = op[0] | op[1];
  assign is_div    = op[2] | op[3];
  assign is_signed = op[0] | op[2];
  assign busy      = (state_q == StMul) || (state_q == StDiv);
  // Gate on resetn so a held EX instruction cannot appear to issue while in reset.
  assign issue        = resetn & ex_valid & (is_mul | is_div) & (state_q == StIdle) & ~exception;
  assign mult_div_run = issue | (busy & ~exception);

  assign mag_a = (is_signed & src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign mag_b = (is_signed & src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  // Shift-add step: low half of p_q holds the remaining multiplier bits.
  assign mul_upper = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});
  assign mul_next  = {mul_upper, p_q[WIDTH-1:1]};
  assign mul_res   = neg_q ? (~mul_next + 1'b1) : mul_next;

  // Restoring step: {remainder, dividend/quotient} shifted left one bit per cycle.
  assign div_rs   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_rs - {1'b0, mb_q};
  assign div_next = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
  assign div_quo  = dz_q  ? {WIDTH{1'b1}}
                  : neg_q ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
  assign div_rem  = neg_rem_q ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1) : div_next[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod, fast_res;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign fast_res  = (is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? (~fast_prod + 1'b1)
                                                                     : fast_prod;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      p_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (exception) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            cnt_q     <= '0;
            ma_q      <= mag_a;
            mb_q      <= mag_b;
            p_q       <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
            neg_q     <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_q <= is_signed & src_a[WIDTH-1];
            dz_q      <= (src_b == '0);
`ifdef MDU_FAST_MUL_EN
            if (is_mul) begin
              {hi_q, lo_q} <= fast_res;
              state_q      <= StDone;
            end else begin
              state_q <= StDiv;
            end
`else
            state_q <= is_mul ? StMul : StDiv;
`endif
          end else if (ex_valid & op[5]) begin
            hi_q <= src_a;
          end else if (ex_valid & op[4]) begin
            lo_q <= src_a;
          end
        end
        StMul: begin
          p_q   <= mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            {hi_q, lo_q} <= mul_res;
            state_q      <= StDone;
          end
        end
        StDiv: begin
          p_q   <= div_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            hi_q    <= div_rem;
            lo_q    <= div_quo;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
